// File: rtl/stacker_pkg.sv
// Shared definitions for the stacker game datapath: frame geometry, scan
// state encoding and the row one-hot decode used by both FSM and display.
package stacker_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = 3;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  function automatic logic [ROWS-1:0] onehot(input logic [ROW_W-1:0] idx);
    logic [ROWS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/frame_scan_buffer_scan_timer.sv
// Row-slot timer for the LED scan: divides clk into SCAN_DIV-cycle slots,
// steps the scanned row and flags slot boundaries and frame wrap.
module scan_timer
  import stacker_pkg::*;
#(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ROW_W-1:0] scan_row,
  output logic             blank_end,
  output logic             slot_end,
  output logic             frame_done
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;

  assign blank_end = (div_cnt == CNT_W'(BLANK_CYC - 1));
  assign slot_end  = (div_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      scan_row   <= '0;
      frame_done <= 1'b0;
    end else begin
      // Pulse lands on the first blank cycle of row 0.
      frame_done <= slot_end && (scan_row == ROW_W'(ROWS - 1));
      if (slot_end) begin
        div_cnt  <= '0;
        scan_row <= scan_row + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scan_buffer.sv
// 8x8 frame store with a debug read port, scanned out row by row to a
// multiplexed LED matrix with a blanking gap at the start of each slot.
module frame_scan_buffer
  import stacker_pkg::*;
#(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_strobe,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             clr_array,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data,
  output logic [ROWS-1:0]  row_sel,
  output logic [COLS-1:0]  col_data,
  output logic             frame_done
);

  logic [COLS-1:0] mem [ROWS];
  logic [ROW_W-1:0] scan_row;
  logic             blank_end;
  logic             slot_end;
  scan_state_t      state;

  scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan_timer (
    .clk        (clk),
    .reset      (reset),
    .scan_row   (scan_row),
    .blank_end  (blank_end),
    .slot_end   (slot_end),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk) begin
    if (reset || clr_array) begin
      for (int i = 0; i < ROWS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_strobe) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_row];
    end
  end

  // col_data is a snapshot taken at drive start, so mid-slot writes wait a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BLANK;
      row_sel  <= '0;
      col_data <= '0;
    end else begin
      case (state)
        BLANK: begin
          if (blank_end) begin
            state    <= DRIVE;
            row_sel  <= onehot(scan_row);
            col_data <= mem[scan_row];
          end
        end
        DRIVE: begin
          if (slot_end) begin
            state    <= BLANK;
            row_sel  <= '0;
            col_data <= '0;
          end else if (clr_array) begin
            col_data <= '0;
          end
        end
        default: begin
          state    <= BLANK;
          row_sel  <= '0;
          col_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scan_buffer.sv
// Directed bench for frame_scan_buffer with SCAN_DIV=8, BLANK_CYC=2.
module tb_frame_scan_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_strobe = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       clr_array = 1'b0;
  logic [2:0] rd_row = '0;
  logic [7:0] rd_data;
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic       frame_done;

  int checks = 0;
  int failures = 0;
  int k = 0;        // edges since reset release; outputs sampled on negedge
  int pulses = 0;

  frame_scan_buffer #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_strobe  (wr_strobe),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .clr_array  (clr_array),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Slot of 8 cycles: 2 blank, then 6 driving row (k/8)%8.
  function automatic logic [7:0] exp_row_sel(input int kk);
    logic [7:0] one;
    one = 8'h01;
    if ((kk % 8) >= 2) return one << ((kk / 8) % 8);
    return 8'h00;
  endfunction

  function automatic logic exp_frame_done(input int kk);
    return (kk != 0) && ((kk % 64) == 0);
  endfunction

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      checks++;
      if (row_sel !== exp_row_sel(k)) begin
        failures++;
        $display("FAIL row_sel k=%0d got=%h exp=%h", k, row_sel, exp_row_sel(k));
      end
      checks++;
      if (frame_done !== exp_frame_done(k)) begin
        failures++;
        $display("FAIL frame_done k=%0d got=%b exp=%b", k, frame_done, exp_frame_done(k));
      end
      if (frame_done === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({row_sel, col_data, rd_data, frame_done} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got row_sel=%h col=%h rd=%h fd=%b exp all 0",
               row_sel, col_data, rd_data, frame_done);
    end
    reset = 1'b0;
    k = 0;
    $display("test_reset: outputs idle after 3 reset cycles");
  endtask

  task automatic test_scan_basic();
    logic [7:0] exp_col;
    for (int i = 0; i < 64; i++) begin
      exp_col = (exp_row_sel(k) == 8'h08) ? 8'hE0 : 8'h00;
      checks++;
      if (col_data !== exp_col) begin
        failures++;
        $display("FAIL scan_col k=%0d got=%h exp=%h", k, col_data, exp_col);
      end
      wr_strobe = (k == 5);
      wr_row    = 3'd3;
      wr_data   = 8'hE0;
      advance(1);
    end
    wr_strobe = 1'b0;
    $display("test_scan_basic: first frame scanned, row 3 showed E0");
  endtask

  task automatic test_snapshot();
    advance(67 - k);
    checks++;
    if (row_sel !== 8'h01 || col_data !== 8'h00) begin
      failures++;
      $display("FAIL snap_pre got row_sel=%h col=%h exp 01/00", row_sel, col_data);
    end
    wr_strobe = 1'b1; wr_row = 3'd0; wr_data = 8'hFF;
    advance(1);
    wr_strobe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (col_data !== 8'h00) begin
        failures++;
        $display("FAIL snap_hold k=%0d got=%h exp=00", k, col_data);
      end
      advance(1);
    end
    advance(130 - k);
    checks++;
    if (col_data !== 8'hFF) begin
      failures++;
      $display("FAIL snap_next got=%h exp=FF", col_data);
    end
    $display("test_snapshot: row 0 write deferred to next frame");
  endtask

  task automatic test_clear();
    for (int r = 1; r < 8; r++) begin
      wr_strobe = 1'b1; wr_row = 3'(r); wr_data = 8'hFF;
      advance(1);
    end
    wr_strobe = 1'b0;
    advance(147 - k);
    checks++;
    if (row_sel !== 8'h04 || col_data !== 8'hFF) begin
      failures++;
      $display("FAIL clr_pre got row_sel=%h col=%h exp 04/FF", row_sel, col_data);
    end
    clr_array = 1'b1; wr_strobe = 1'b1; wr_row = 3'd2; wr_data = 8'h0F;
    advance(1);
    clr_array = 1'b0; wr_strobe = 1'b0;
    checks++;
    if (row_sel !== 8'h04 || col_data !== 8'h00) begin
      failures++;
      $display("FAIL clr_col got row_sel=%h col=%h exp 04/00", row_sel, col_data);
    end
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      advance(1);
      checks++;
      if (rd_data !== 8'h00) begin
        failures++;
        $display("FAIL clr_read row=%0d got=%h exp=00", r, rd_data);
      end
    end
    $display("test_clear: clear beat simultaneous write, all rows zero");
  endtask

  task automatic test_free_run();
    pulses = 0;
    advance(192);
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL frame_pulses got=%0d exp=3", pulses);
    end
    $display("test_free_run: %0d frame pulses in 192 cycles", pulses);
  endtask

  task automatic test_read_port();
    wr_strobe = 1'b1; wr_row = 3'd5; wr_data = 8'h3C;
    advance(1);
    wr_strobe = 1'b0; rd_row = 3'd5;
    advance(1);
    checks++;
    if (rd_data !== 8'h3C) begin
      failures++;
      $display("FAIL read_row5 got=%h exp=3C", rd_data);
    end
    rd_row = 3'd6; wr_strobe = 1'b1; wr_row = 3'd6; wr_data = 8'h55;
    advance(1);
    wr_strobe = 1'b0;
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("FAIL read_before_write got=%h exp=00", rd_data);
    end
    advance(1);
    checks++;
    if (rd_data !== 8'h55) begin
      failures++;
      $display("FAIL read_after_write got=%h exp=55", rd_data);
    end
    $display("test_read_port: 1-cycle latency, read-before-write ok");
  endtask

  task automatic test_reset_mid_slot();
    int guard;
    guard = 0;
    while ((k % 64) != 36 && guard < 64) begin
      advance(1);
      guard++;
    end
    checks++;
    if (row_sel !== 8'h10) begin
      failures++;
      $display("FAIL mid_slot_pre got=%h exp=10", row_sel);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({row_sel, col_data, rd_data, frame_done} !== 25'd0) begin
      failures++;
      $display("FAIL mid_reset got row_sel=%h col=%h rd=%h fd=%b exp all 0",
               row_sel, col_data, rd_data, frame_done);
    end
    reset = 1'b0;
    k = 0;
    advance(2);
    checks++;
    if (row_sel !== 8'h01 || col_data !== 8'h00) begin
      failures++;
      $display("FAIL restart got row_sel=%h col=%h exp 01/00", row_sel, col_data);
    end
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      advance(1);
      checks++;
      if (rd_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_read row=%0d got=%h exp=00", r, rd_data);
      end
    end
    $display("test_reset_mid_slot: scan restarted at row 0, store cleared");
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_snapshot();
    test_clear();
    test_free_run();
    test_read_port();
    test_reset_mid_slot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
